layer_sequencer: RTL and testbench
==================================

# layer_sequencer

Hardware sequencer for the single-cycle processor's special-instruction datapath. For each candidate move it drives the register file's layer-level commands (decode, load weights/biases, systolic compute, ifmap update) across all DNN layers. It tracks the signed DNN score per move and issues the optimal-move send once every move is evaluated. It replaces the hand-written microcode loop that currently steps these commands through the PC.

## Interface
- `MOVE_WIDTH`, 16: width of the move id presented to the register file.
- `TIMEOUT`, 1024: maximum cycles any command may wait for `next_pc` before error.
- `clk` in 1: clock.
- `nrst` in 1: asynchronous, active-low reset.
- `start_iv` in 1: single-cycle start pulse; ignored while `busy_o`.
- `total_moves_id` in 8: number of moves to evaluate; latched on `start_iv`.
- `move_id_i` in MOVE_WIDTH: id of the move at index `move_idx_o`; combinational from the move table.
- `layer_total_num_i` in 4: layer count from the register file; sampled after `decode_layer` completes.
- `next_pc` in 1: register file completion strobe.
- `dnn_iv` in 1: DNN output valid.
- `dnn_id` in 8: DNN output score, signed.
- `move_current_ov` out 1: load current move into the register file.
- `move_current_od` out MOVE_WIDTH: current move id.
- `decode_layer`, `decode_layer_info`, `compute_ifmap`, `send_layer_info`, `load_weights`, `load_biases`, `send_systolic_data`, `set_ifmap_o`, `send_optimal_move` out 1 each: register file commands.
- `move_idx_o` out 8: current move index.
- `layer_idx_o` out 4: current layer, 1-based.
- `best_move_od` out 8: index of the best move so far.
- `busy_o` out 1: sequencer active.
- `done_o` out 1: single-cycle pulse at the end of a run.
- `err_o` out 1: sticky error flag; cleared on `start_iv`.

## Operation
- States: IDLE, MOVE_LD, DEC_L, DEC_LI, IFMAP, SEND_LI, LD_W, LD_B, SA, SET_O, NEXT_L, WAIT_DNN, NEXT_M, SEND_OPT, FIN.
- IDLE: on `start_iv`, latch `total_moves_id`, clear the move/layer counters, best score, best index and `err_o`.
  - If `total_moves_id == 0`, go to FIN without issuing any commands and leave `best_move_od = 0`.
  - Otherwise go to MOVE_LD.
- MOVE_LD: pulse `move_current_ov` for one cycle with `move_current_od = move_id_i`, then go to DEC_L.
- Command states (DEC_L through SET_O): assert the state's single command output. Hold it high until a cycle in which `next_pc = 1`, then advance to the next state. At most one command output is high in any cycle.
- After DEC_L completes, latch `layer_total_num_i`. A value of 0 sets `err_o` and is treated as 1.
- NEXT_L:
  - If `layer_idx_o < layer_total`, increment `layer_idx_o` and go to DEC_LI.
  - Otherwise go to WAIT_DNN.
- WAIT_DNN: on `dnn_iv`, go to NEXT_M. If `$signed(dnn_id) > best_score`, or this is the first move, update the best score and `best_move_od`. Ties keep the earlier move.
- NEXT_M:
  - If `move_idx_o + 1 < total_moves`, increment `move_idx_o`, reset `layer_idx_o` to 1, and go to MOVE_LD.
  - Otherwise go to SEND_OPT.
- SEND_OPT: assert `send_optimal_move` for one cycle, then go to FIN.
- FIN: pulse `done_o` for one cycle and go to IDLE.
- Watchdog: counts cycles in each command state and in WAIT_DNN; cleared on every state change. On reaching `TIMEOUT`: set `err_o`, drop all commands, go to FIN (no `send_optimal_move`).
- `dnn_iv` outside WAIT_DNN is ignored.

## Timing
- Reset values: all outputs 0; `layer_idx_o = 1`; state IDLE. An asserted `nrst` mid-run abandons the run immediately with no `done_o`.
- Latency from `start_iv` to `move_current_ov` is 1 cycle.
- Single-cycle commands (`next_pc` high in the same cycle) occupy exactly 1 cycle each.
- Multi-cycle commands (`load_weights`, `load_biases`, `send_systolic_data`) are held level until `next_pc`. The register file depends on this level for its state transitions.
- Command outputs are registered, i.e. driven from the state register; no combinational path from `next_pc` to a command output.
- Per layer with single-cycle responses: DEC_LI → SET_O plus NEXT_L = 8 cycles. The first layer adds MOVE_LD and DEC_L.

## Structure
- Shared package `layer_seq_pkg`: state enum `seq_state_t`, the command-index constants, and the default `TIMEOUT`.
- One sub-module, `seq_watchdog`: counter with clear/enable/expire.
- Best-score tracking stays inline.

## Test plan
- Responsive register file model (`next_pc = 1` in every command cycle), 2 moves, 2 layers, scores 5 then −3: 2 MOVE_LD pulses; command order DEC_L, {DEC_LI, IFMAP, SEND_LI, LD_W, LD_B, SA, SET_O}×2 per move; `best_move_od = 0`; `send_optimal_move` once; then `done_o`.
- `load_weights` with `next_pc` delayed 12 cycles: `load_weights` high for exactly 12 cycles; no other command asserted meanwhile.
- Scores 3, 7, 7, −128 over 4 moves: `best_move_od = 1` (tie keeps the earlier move; negative handled signed).
- `total_moves_id = 0`: no commands issued; `done_o` 1 cycle after start; `err_o = 0`.
- `next_pc` never asserted during SA: `err_o` rises after `TIMEOUT` cycles; no `send_optimal_move`; `done_o` pulses.
- `nrst` asserted mid LD_B, then a new `start_iv`: all outputs 0 during reset; the new run starts cleanly at move 0, layer 1.

Source files
------------

// File: rtl/layer_sequencer_pkg.sv
// layer_seq_pkg: shared types and constants for the layer sequencer.
//   seq_state_t     - sequencer FSM state encoding
//   CMD_*           - bit positions of the register-file commands in a command vector
//   TIMEOUT_DEFAULT - default watchdog limit in cycles
package layer_seq_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 1024;

    localparam int N_CMD        = 9;
    localparam int CMD_DEC_L    = 0;
    localparam int CMD_DEC_LI   = 1;
    localparam int CMD_IFMAP    = 2;
    localparam int CMD_SEND_LI  = 3;
    localparam int CMD_LD_W     = 4;
    localparam int CMD_LD_B     = 5;
    localparam int CMD_SA       = 6;
    localparam int CMD_SET_O    = 7;
    localparam int CMD_SEND_OPT = 8;

    typedef enum logic [3:0] {
        S_IDLE, S_MOVE_LD, S_DEC_L, S_DEC_LI, S_IFMAP, S_SEND_LI, S_LD_W, S_LD_B,
        S_SA, S_SET_O, S_NEXT_L, S_WAIT_DNN, S_NEXT_M, S_SEND_OPT, S_FIN
    } seq_state_t;

    // One-hot command vector for a state; all-zero for non-command states.
    function automatic logic [N_CMD-1:0] state_cmd(seq_state_t s);
        logic [N_CMD-1:0] v;
        v = '0;
        case (s)
            S_DEC_L:    v[CMD_DEC_L]    = 1'b1;
            S_DEC_LI:   v[CMD_DEC_LI]   = 1'b1;
            S_IFMAP:    v[CMD_IFMAP]    = 1'b1;
            S_SEND_LI:  v[CMD_SEND_LI]  = 1'b1;
            S_LD_W:     v[CMD_LD_W]     = 1'b1;
            S_LD_B:     v[CMD_LD_B]     = 1'b1;
            S_SA:       v[CMD_SA]       = 1'b1;
            S_SET_O:    v[CMD_SET_O]    = 1'b1;
            S_SEND_OPT: v[CMD_SEND_OPT] = 1'b1;
            default:    v = '0;
        endcase
        return v;
    endfunction

    // States in which the sequencer waits on an external strobe.
    function automatic logic is_wait_state(seq_state_t s);
        return (s >= S_DEC_L && s <= S_SET_O) || (s == S_WAIT_DNN);
    endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// layer_seq_if: register-file / DNN side of the layer sequencer.
//   master - sequencer: drives move load and layer commands, receives
//            move id, layer count, next_pc and DNN score.
//   slave  - register file / DNN side.
interface layer_seq_if #(parameter int MOVE_WIDTH = 16);
    logic                  move_current_ov;
    logic [MOVE_WIDTH-1:0] move_current_od;
    logic                  decode_layer;
    logic                  decode_layer_info;
    logic                  compute_ifmap;
    logic                  send_layer_info;
    logic                  load_weights;
    logic                  load_biases;
    logic                  send_systolic_data;
    logic                  set_ifmap_o;
    logic                  send_optimal_move;
    logic [MOVE_WIDTH-1:0] move_id_i;
    logic [3:0]            layer_total_num_i;
    logic                  next_pc;
    logic                  dnn_iv;
    logic [7:0]            dnn_id;

    modport master (
        output move_current_ov, move_current_od, decode_layer, decode_layer_info,
               compute_ifmap, send_layer_info, load_weights, load_biases,
               send_systolic_data, set_ifmap_o, send_optimal_move,
        input  move_id_i, layer_total_num_i, next_pc, dnn_iv, dnn_id
    );

    modport slave (
        input  move_current_ov, move_current_od, decode_layer, decode_layer_info,
               compute_ifmap, send_layer_info, load_weights, load_biases,
               send_systolic_data, set_ifmap_o, send_optimal_move,
        output move_id_i, layer_total_num_i, next_pc, dnn_iv, dnn_id
    );
endinterface

// File: rtl/layer_sequencer_watchdog.sv
// seq_watchdog: per-state wait limiter.
//   clk, nrst - clock, async active-low reset
//   clr       - reload the counter (state change)
//   en        - count this cycle (sequencer is in a waiting state)
//   expire    - high in the TIMEOUT-th consecutive enabled cycle
module seq_watchdog #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic nrst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = LOAD;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = en && (cnt_q == '0);
endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: steps the register file through every DNN layer for each
// candidate move, tracks the best signed score and issues the optimal-move send.
//   clk, nrst       - clock, async active-low reset
//   start_iv        - start pulse (ignored while busy), total_moves_id latched
//   bus             - register-file commands, move load, next_pc, DNN score
//   move_idx_o      - current move index; layer_idx_o - current layer (1-based)
//   best_move_od    - index of best move so far
//   busy_o, done_o  - active / end-of-run pulse; err_o - sticky error
//
// state      | meaning
// IDLE       | wait for start_iv
// MOVE_LD    | load current move id into the register file
// DEC_L      | decode layer count
// DEC_LI..SET_O | per-layer commands, each held until next_pc
// NEXT_L     | advance layer or finish the move
// WAIT_DNN   | wait for score, update best
// NEXT_M     | advance move or finish
// SEND_OPT   | issue optimal-move send
// FIN        | done pulse
module layer_sequencer
    import layer_seq_pkg::*;
#(
    parameter int          MOVE_WIDTH = 16,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start_iv,
    input  logic [7:0]  total_moves_id,
    layer_seq_if.master bus,
    output logic [7:0]  move_idx_o,
    output logic [3:0]  layer_idx_o,
    output logic [7:0]  best_move_od,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);
    seq_state_t            state_q, state_d;
    logic [7:0]            total_q, total_d;
    logic [7:0]            move_idx_q, move_idx_d;
    logic [3:0]            layer_idx_q, layer_idx_d;
    logic [3:0]            layer_total_q, layer_total_d;
    logic signed [7:0]     best_score_q, best_score_d;
    logic [7:0]            best_move_q, best_move_d;
    logic                  err_q, err_d;
    logic [MOVE_WIDTH-1:0] cur_move_q, cur_move_d;
    logic                  wd_expire;
    logic [N_CMD-1:0]      cmd;

    always_comb begin
        state_d       = state_q;
        total_d       = total_q;
        move_idx_d    = move_idx_q;
        layer_idx_d   = layer_idx_q;
        layer_total_d = layer_total_q;
        best_score_d  = best_score_q;
        best_move_d   = best_move_q;
        err_d         = err_q;
        cur_move_d    = cur_move_q;
        case (state_q)
            S_IDLE: if (start_iv) begin
                total_d      = total_moves_id;
                move_idx_d   = '0;
                layer_idx_d  = 4'd1;
                best_score_d = '0;
                best_move_d  = '0;
                err_d        = 1'b0;
                state_d      = (total_moves_id == 8'd0) ? S_FIN : S_MOVE_LD;
            end
            S_MOVE_LD: begin
                cur_move_d = bus.move_id_i;
                state_d    = S_DEC_L;
            end
            S_DEC_L: if (bus.next_pc) begin
                // A zero layer count is flagged but still runs one layer.
                if (bus.layer_total_num_i == 4'd0) begin
                    err_d         = 1'b1;
                    layer_total_d = 4'd1;
                end else begin
                    layer_total_d = bus.layer_total_num_i;
                end
                state_d = S_DEC_LI;
            end
            S_DEC_LI:  if (bus.next_pc) state_d = S_IFMAP;
            S_IFMAP:   if (bus.next_pc) state_d = S_SEND_LI;
            S_SEND_LI: if (bus.next_pc) state_d = S_LD_W;
            S_LD_W:    if (bus.next_pc) state_d = S_LD_B;
            S_LD_B:    if (bus.next_pc) state_d = S_SA;
            S_SA:      if (bus.next_pc) state_d = S_SET_O;
            S_SET_O:   if (bus.next_pc) state_d = S_NEXT_L;
            S_NEXT_L: begin
                if (layer_idx_q < layer_total_q) begin
                    layer_idx_d = layer_idx_q + 4'd1;
                    state_d     = S_DEC_LI;
                end else begin
                    state_d = S_WAIT_DNN;
                end
            end
            S_WAIT_DNN: if (bus.dnn_iv) begin
                // Strict compare: ties keep the earlier move.
                if ((move_idx_q == 8'd0) || ($signed(bus.dnn_id) > best_score_q)) begin
                    best_score_d = $signed(bus.dnn_id);
                    best_move_d  = move_idx_q;
                end
                state_d = S_NEXT_M;
            end
            S_NEXT_M: begin
                if (({1'b0, move_idx_q} + 9'd1) < {1'b0, total_q}) begin
                    move_idx_d  = move_idx_q + 8'd1;
                    layer_idx_d = 4'd1;
                    state_d     = S_MOVE_LD;
                end else begin
                    state_d = S_SEND_OPT;
                end
            end
            S_SEND_OPT: state_d = S_FIN;
            S_FIN:      state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        // A completion in the expiring cycle wins over the timeout.
        if (wd_expire && (state_d == state_q)) begin
            err_d   = 1'b1;
            state_d = S_FIN;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= S_IDLE;
            total_q       <= '0;
            move_idx_q    <= '0;
            layer_idx_q   <= 4'd1;
            layer_total_q <= 4'd1;
            best_score_q  <= '0;
            best_move_q   <= '0;
            err_q         <= 1'b0;
            cur_move_q    <= '0;
        end else begin
            state_q       <= state_d;
            total_q       <= total_d;
            move_idx_q    <= move_idx_d;
            layer_idx_q   <= layer_idx_d;
            layer_total_q <= layer_total_d;
            best_score_q  <= best_score_d;
            best_move_q   <= best_move_d;
            err_q         <= err_d;
            cur_move_q    <= cur_move_d;
        end
    end

    seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .nrst   (nrst),
        .clr    (state_d != state_q),
        .en     (is_wait_state(state_q)),
        .expire (wd_expire)
    );

    // Commands decode the state register only, so next_pc never reaches them combinationally.
    assign cmd                    = state_cmd(state_q);
    assign bus.decode_layer       = cmd[CMD_DEC_L];
    assign bus.decode_layer_info  = cmd[CMD_DEC_LI];
    assign bus.compute_ifmap      = cmd[CMD_IFMAP];
    assign bus.send_layer_info    = cmd[CMD_SEND_LI];
    assign bus.load_weights       = cmd[CMD_LD_W];
    assign bus.load_biases        = cmd[CMD_LD_B];
    assign bus.send_systolic_data = cmd[CMD_SA];
    assign bus.set_ifmap_o        = cmd[CMD_SET_O];
    assign bus.send_optimal_move  = cmd[CMD_SEND_OPT];
    assign bus.move_current_ov    = (state_q == S_MOVE_LD);
    assign bus.move_current_od    = (state_q == S_MOVE_LD) ? bus.move_id_i : cur_move_q;

    assign move_idx_o   = move_idx_q;
    assign layer_idx_o  = layer_idx_q;
    assign best_move_od = best_move_q;
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_FIN);
    assign err_o        = err_q;
endmodule

// File: tb/tb_layer_sequencer.sv
module tb_layer_sequencer;
    localparam int TMO    = 1024;
    localparam int BUDGET = 4000;
    localparam int EV_MOVE = 9;
    localparam int EV_DONE = 10;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       start_iv = 1'b0;
    logic [7:0] total_moves_id = '0;
    logic [7:0] move_idx_o, best_move_od;
    logic [3:0] layer_idx_o;
    logic       busy_o, done_o, err_o;

    layer_seq_if #(.MOVE_WIDTH(16)) bus ();

    assign bus.move_id_i = 16'h5A00 ^ {8'h00, move_idx_o};

    layer_sequencer #(.MOVE_WIDTH(16), .TIMEOUT(TMO)) dut (
        .clk            (clk),
        .nrst           (nrst),
        .start_iv       (start_iv),
        .total_moves_id (total_moves_id),
        .bus            (bus),
        .move_idx_o     (move_idx_o),
        .layer_idx_o    (layer_idx_o),
        .best_move_od   (best_move_od),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    typedef struct {
        int               n;
        int               layers;
        int               d_lw;
        int               d_oth;
        bit               sa_never;
        logic [7:0][7:0]  sc;
        int               exp_best;
        int               exp_err;
    } vec_t;

    vec_t vecs[8];
    int   dly[9];
    bit   sa_never_g;
    int   exp_q[$];
    int   got_q[$];
    int   hold_c[$];
    int   hold_v[$];

    function automatic int ev(input int c, input int m, input int l);
        return c * 65536 + m * 256 + l;
    endfunction

    function automatic logic [15:0] id_of(input int m);
        return 16'h5A00 ^ 16'(m);
    endfunction

    // Best move: index of the first occurrence of the maximum signed score.
    function automatic int best_of(input logic [7:0][7:0] sc, input int n);
        int mx;
        mx = -1000;
        for (int i = 0; i < n; i++) if (int'($signed(sc[i])) > mx) mx = int'($signed(sc[i]));
        for (int i = 0; i < n; i++) if (int'($signed(sc[i])) == mx) return i;
        return 0;
    endfunction

    // Expected command/event order and the cycle (after start) of done_o,
    // assuming a one-cycle DNN wait; extra DNN wait cycles are added by the driver.
    task automatic build_model(input int n, input int layers, output int done_k);
        int le, sum;
        le = (layers == 0) ? 1 : layers;
        sum = 0;
        exp_q.delete();
        if (n == 0) begin
            exp_q.push_back(ev(EV_DONE, 0, 0));
            done_k = 1;
            return;
        end
        for (int m = 0; m < n; m++) begin
            exp_q.push_back(ev(EV_MOVE, m, 1)); sum += 1;
            exp_q.push_back(ev(0, m, 1));       sum += dly[0];
            for (int l = 1; l <= le; l++) begin
                for (int c = 1; c <= 7; c++) begin
                    exp_q.push_back(ev(c, m, l));
                    if (c == 6 && sa_never_g) begin
                        sum += TMO;
                        exp_q.push_back(ev(EV_DONE, 0, 0));
                        done_k = sum + 1;
                        return;
                    end
                    sum += dly[c];
                end
                sum += 1;
            end
            sum += 2;
        end
        exp_q.push_back(ev(8, 0, 0)); sum += 1;
        exp_q.push_back(ev(EV_DONE, 0, 0));
        done_k = sum + 1;
    endtask

    task automatic run_case(input string tag, input int n, input int layers,
                            input logic [7:0][7:0] sc, input int exp_best, input int exp_err);
        int hold[9];
        int exp_k, k, done_cnt, done_k, first_mv, mv_cnt, od_err, oh_err;
        int post, phase, wait_left, extra, active, le, m_cur, bad, first_bad, n_opt;
        bit np;
        logic [8:0] cv;
        got_q.delete(); hold_c.delete(); hold_v.delete();
        foreach (hold[i]) hold[i] = 0;
        done_cnt = 0; done_k = -1; first_mv = -1; mv_cnt = 0; od_err = 0; oh_err = 0;
        post = 0; phase = 0; wait_left = 0; extra = 0;
        le = (layers == 0) ? 1 : layers;
        build_model(n, layers, exp_k);

        @(negedge clk);
        total_moves_id = 8'(n);
        bus.layer_total_num_i = 4'(layers);
        bus.next_pc = 1'b0;
        bus.dnn_iv = 1'b0;
        start_iv = 1'b1;
        @(negedge clk);
        start_iv = 1'b0;
        k = 1;
        while (k <= BUDGET && post < 3) begin
            cv = {bus.send_optimal_move, bus.set_ifmap_o, bus.send_systolic_data, bus.load_biases,
                  bus.load_weights, bus.send_layer_info, bus.compute_ifmap,
                  bus.decode_layer_info, bus.decode_layer};
            if ($countones({cv, bus.move_current_ov}) > 1) oh_err++;
            if (bus.move_current_ov) begin
                got_q.push_back(ev(EV_MOVE, int'(move_idx_o), int'(layer_idx_o)));
                if (bus.move_current_od != id_of(mv_cnt)) od_err++;
                if (mv_cnt == 0) first_mv = k;
                mv_cnt++;
            end
            active = -1;
            for (int c = 0; c < 9; c++) begin
                if (cv[c]) begin
                    if (hold[c] == 0)
                        got_q.push_back((c == 8) ? ev(8, 0, 0) : ev(c, int'(move_idx_o), int'(layer_idx_o)));
                    hold[c]++;
                    if (active < 0) active = c;
                end else if (hold[c] > 0) begin
                    hold_c.push_back(c); hold_v.push_back(hold[c]); hold[c] = 0;
                end
            end
            if (done_o) begin
                got_q.push_back(ev(EV_DONE, 0, 0));
                done_cnt++;
                done_k = k;
            end
            m_cur = (mv_cnt > 0) ? mv_cnt - 1 : 0;
            bus.dnn_iv = 1'b0;
            bus.dnn_id = 8'd127;
            if (phase == 2) begin
                if (wait_left == 0) begin
                    bus.dnn_iv = 1'b1;
                    bus.dnn_id = sc[m_cur & 7];
                    phase = 0;
                end else wait_left--;
            end else if (phase == 1) begin
                bus.dnn_iv = 1'b1;       // NEXT_L cycle: must be ignored
                phase = 2;
                wait_left = $urandom_range(0, 2);
                extra += wait_left;
            end else if (active >= 0 && $urandom_range(0, 3) == 0) begin
                bus.dnn_iv = 1'b1;       // during a command: must be ignored
            end
            np = 1'b0;
            if (active >= 0) begin
                np = (hold[active] >= dly[active]);
                if (active == 6 && sa_never_g) np = 1'b0;
            end
            bus.next_pc = np;
            if (active == 7 && np && int'(layer_idx_o) == le) phase = 1;
            if (done_cnt > 0) post++;
            @(negedge clk);
            k++;
        end
        for (int c = 0; c < 9; c++) if (hold[c] > 0) begin
            hold_c.push_back(c); hold_v.push_back(hold[c]);
        end
        bus.next_pc = 1'b0;
        bus.dnn_iv = 1'b0;

        first_bad = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (first_bad < 0 && (i >= got_q.size() || got_q[i] != exp_q[i])) first_bad = i;
        end
        if (first_bad < 0 && got_q.size() != exp_q.size()) first_bad = exp_q.size();
        check($sformatf("%s.event_order(len %0d vs %0d)", tag, got_q.size(), exp_q.size()), first_bad, -1);
        bad = 0;
        for (int i = 0; i < hold_c.size(); i++) begin
            int want;
            want = (hold_c[i] == 8) ? 1 : (hold_c[i] == 6 && sa_never_g) ? TMO : dly[hold_c[i]];
            if (hold_v[i] != want) bad++;
        end
        check({tag, ".hold_lengths_bad"}, bad, 0);
        n_opt = 0;
        foreach (got_q[i]) if (got_q[i] == ev(8, 0, 0)) n_opt++;
        check({tag, ".send_optimal_count"}, n_opt, (n > 0 && !sa_never_g) ? 1 : 0);
        check({tag, ".done_count"}, done_cnt, 1);
        check({tag, ".done_cycle"}, done_k, exp_k + extra);
        if (n > 0) check({tag, ".start_to_move_latency"}, first_mv, 1);
        check({tag, ".best_move"}, int'(best_move_od), exp_best);
        check({tag, ".err"}, int'(err_o), exp_err);
        check({tag, ".multi_cmd_cycles"}, oh_err, 0);
        check({tag, ".move_od_bad"}, od_err, 0);
        check({tag, ".busy_after"}, int'(busy_o), 0);
    endtask

    task automatic abort_in_ldb();
        int lbc, dn;
        lbc = 0; dn = 0;
        foreach (dly[i]) dly[i] = 1;
        @(negedge clk);
        total_moves_id = 8'd2;
        bus.layer_total_num_i = 4'd2;
        start_iv = 1'b1;
        @(negedge clk);
        start_iv = 1'b0;
        for (int k = 0; k < 200 && lbc < 2; k++) begin
            if (bus.load_biases) lbc++;
            bus.next_pc = !bus.load_biases;
            if (lbc < 2) @(negedge clk);
        end
        check("rst.reached_ld_b", lbc, 2);
        nrst = 1'b0;
        bus.next_pc = 1'b0;
        #1;
        check("rst.outputs_ones", $countones({bus.move_current_ov, bus.move_current_od, bus.decode_layer,
              bus.decode_layer_info, bus.compute_ifmap, bus.send_layer_info, bus.load_weights,
              bus.load_biases, bus.send_systolic_data, bus.set_ifmap_o, bus.send_optimal_move,
              move_idx_o, best_move_od, busy_o, done_o, err_o}), 0);
        check("rst.layer_idx", int'(layer_idx_o), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done_o || busy_o) dn++;
        end
        check("rst.held_quiet", dn, 0);
        nrst = 1'b1;
    endtask

    task automatic set_vec(input int i, input int n, input int layers, input int d_lw, input int d_oth,
                           input bit sa, input int s0, input int s1, input int s2, input int s3,
                           input int best, input int err);
        vecs[i].n = n; vecs[i].layers = layers; vecs[i].d_lw = d_lw; vecs[i].d_oth = d_oth;
        vecs[i].sa_never = sa;
        vecs[i].sc = '0;
        vecs[i].sc[0] = 8'(s0); vecs[i].sc[1] = 8'(s1);
        vecs[i].sc[2] = 8'(s2); vecs[i].sc[3] = 8'(s3);
        vecs[i].exp_best = best; vecs[i].exp_err = err;
    endtask

    task automatic apply_vec(input int i, input string tag);
        foreach (dly[c]) dly[c] = vecs[i].d_oth;
        dly[4] = vecs[i].d_lw;
        dly[8] = 1;
        sa_never_g = vecs[i].sa_never;
        run_case(tag, vecs[i].n, vecs[i].layers, vecs[i].sc, vecs[i].exp_best, vecs[i].exp_err);
    endtask

    initial begin
        logic [7:0][7:0] rs;
        int rn, rl;
        bus.next_pc = 1'b0;
        bus.dnn_iv = 1'b0;
        bus.dnn_id = '0;
        bus.layer_total_num_i = '0;
        sa_never_g = 1'b0;

        //       idx n  L  lw  oth sa  scores              best err
        set_vec(0,   2, 2, 1,  1,  0,  5,    -3,  0,   0,    0,  0);
        set_vec(1,   1, 1, 12, 1,  0,  9,     0,  0,   0,    0,  0);
        set_vec(2,   4, 1, 1,  1,  0,  3,     7,  7,   -128, 1,  0);
        set_vec(3,   0, 2, 1,  1,  0,  0,     0,  0,   0,    0,  0);
        set_vec(4,   1, 1, 1,  1,  1,  4,     0,  0,   0,    0,  1);
        set_vec(5,   2, 0, 1,  1,  0,  -5,   -2,  0,   0,    1,  1);
        set_vec(6,   3, 2, 3,  2,  0,  -7,   -3, -9,   0,    1,  0);
        set_vec(7,   2, 3, 2,  1,  0,  -128, -128, 0,  0,    0,  0);

        repeat (3) @(negedge clk);
        check("reset.outputs_ones", $countones({bus.move_current_ov, bus.move_current_od, bus.decode_layer,
              bus.decode_layer_info, bus.compute_ifmap, bus.send_layer_info, bus.load_weights,
              bus.load_biases, bus.send_systolic_data, bus.set_ifmap_o, bus.send_optimal_move,
              move_idx_o, best_move_od, busy_o, done_o, err_o}), 0);
        check("reset.layer_idx", int'(layer_idx_o), 1);
        nrst = 1'b1;

        for (int i = 0; i < 8; i++) apply_vec(i, $sformatf("vec%0d", i));

        abort_in_ldb();
        apply_vec(0, "after_reset");

        for (int r = 0; r < 8; r++) begin
            rn = $urandom_range(1, 5);
            rl = $urandom_range(0, 3);
            for (int c = 0; c < 8; c++) dly[c] = $urandom_range(1, 3);
            dly[8] = 1;
            sa_never_g = 1'b0;
            rs = '0;
            for (int i = 0; i < rn; i++) rs[i] = 8'($urandom_range(0, 254) - 128);
            run_case($sformatf("rand%0d", r), rn, rl, rs, best_of(rs, rn), (rl == 0) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
